// File: rtl/ramb4_s16_port_arbiter_if.sv
// Requester and RAM-port signal bundle for ramb4_s16_port_arbiter.
// The slave side is the arbiter. The master side is the requesters plus the RAM read data.
interface ramb4_s16_port_arbiter_if #(
   parameter int AW = 8,
   parameter int DW = 16
);
   logic          req0;
   logic          req1;
   logic          we0;
   logic          we1;
   logic [AW-1:0] addr0;
   logic [AW-1:0] addr1;
   logic [DW-1:0] di0;
   logic [DW-1:0] di1;
   logic          gnt0;
   logic          gnt1;
   logic          rvld0;
   logic          rvld1;
   logic [DW-1:0] do0;
   logic [DW-1:0] do1;
   logic          ram_en;
   logic          ram_we;
   logic          ram_rst;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_di;
   logic [DW-1:0] ram_do;

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, di0, di1, ram_do,
      output gnt0, gnt1, rvld0, rvld1, do0, do1,
      output ram_en, ram_we, ram_rst, ram_addr, ram_di
   );

   modport master (
      output req0, req1, we0, we1, addr0, addr1, di0, di1, ram_do,
      input  gnt0, gnt1, rvld0, rvld1, do0, do1,
      input  ram_en, ram_we, ram_rst, ram_addr, ram_di
   );
endinterface

// File: rtl/ramb4_s16_port_arbiter.sv
// Shares the wide RAMB4 port between two requesters using round-robin with bounded bursts.
// A clear sweep writes FILL to every word after reset and whenever clr_req_i is seen.
module ramb4_s16_port_arbiter #(
   parameter int            AW           = 8,
   parameter int            DW           = 16,
   parameter int            MAX_BURST    = 4,
   parameter logic [DW-1:0] FILL         = 16'h0000,
   parameter bit            CLR_ON_RESET = 1'b1
) (
   input  logic                    clk_i,
   input  logic                    rst_n_i,
   input  logic                    clr_req_i,
   output logic                    clr_busy_o,
   ramb4_s16_port_arbiter_if.slave bus
);
   typedef enum logic {ST_CLEAR = 1'b0, ST_SERVE = 1'b1} state_e;

   localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

   state_e        state_q;
   logic [AW-1:0] clr_addr_q;
   logic          ptr_q;
   logic          ptr_d;
   logic [3:0]    cnt_q;
   logic [3:0]    cnt_d;
   logic [3:0]    cnt_inc_s;
   logic          clr_busy_q;
   logic [1:0]    rvld_q;
   logic          serve_s;
   logic          clear_s;
   logic          gnt0_s;
   logic          gnt1_s;
   logic          win_s;
   logic          other_req_s;
   logic          ram_en_s;
   logic          ram_we_s;
   logic [AW-1:0] ram_addr_s;
   logic [DW-1:0] ram_di_s;

   // The RAM port stays quiet while reset is held, even though the state already reads CLEAR.
   assign serve_s = rst_n_i && (state_q == ST_SERVE);
   assign clear_s = rst_n_i && (state_q == ST_CLEAR);

   // Grant decision: a lone requester always wins, and a tie goes to the pointer.
   always_comb begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
      if (serve_s) begin
         if (bus.req0 && bus.req1) begin
            gnt0_s = ~ptr_q;
            gnt1_s = ptr_q;
         end else begin
            gnt0_s = bus.req0;
            gnt1_s = bus.req1;
         end
      end else begin
         gnt0_s = 1'b0;
         gnt1_s = 1'b0;
      end
   end

   // Pointer and burst-count update. cnt_q counts consecutive grants to the pointer's owner.
   always_comb begin
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      win_s       = gnt1_s;
      other_req_s = gnt1_s ? bus.req0 : bus.req1;
      if (win_s == ptr_q) begin
         cnt_inc_s = (cnt_q >= BURST_MAX) ? BURST_MAX : cnt_q + 4'd1;
      end else begin
         cnt_inc_s = 4'd1;
      end
      if (gnt0_s || gnt1_s) begin
         if (other_req_s && (cnt_inc_s >= BURST_MAX)) begin
            ptr_d = ~win_s;
            cnt_d = 4'd0;
         end else begin
            ptr_d = win_s;
            cnt_d = cnt_inc_s;
         end
      end else if (serve_s && (cnt_q != 4'd0)) begin
         ptr_d = ~ptr_q;
         cnt_d = 4'd0;
      end else begin
         ptr_d = ptr_q;
         cnt_d = cnt_q;
      end
   end

   // RAM port mux: the clear sweep first, then the granted requester, otherwise all zero.
   always_comb begin
      ram_en_s   = 1'b0;
      ram_we_s   = 1'b0;
      ram_addr_s = '0;
      ram_di_s   = '0;
      if (clear_s) begin
         ram_en_s   = 1'b1;
         ram_we_s   = 1'b1;
         ram_addr_s = clr_addr_q;
         ram_di_s   = FILL;
      end else if (gnt0_s) begin
         ram_en_s   = 1'b1;
         ram_we_s   = bus.we0;
         ram_addr_s = bus.addr0;
         ram_di_s   = bus.di0;
      end else if (gnt1_s) begin
         ram_en_s   = 1'b1;
         ram_we_s   = bus.we1;
         ram_addr_s = bus.addr1;
         ram_di_s   = bus.di1;
      end else begin
         ram_en_s   = 1'b0;
         ram_we_s   = 1'b0;
         ram_addr_s = '0;
         ram_di_s   = '0;
      end
   end

   // Sweep/serve state machine with the arbitration state and the read-valid pipeline.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= CLR_ON_RESET ? ST_CLEAR : ST_SERVE;
         clr_addr_q <= '0;
         ptr_q      <= 1'b0;
         cnt_q      <= 4'd0;
         rvld_q     <= 2'b00;
         clr_busy_q <= CLR_ON_RESET;
      end else begin
         ptr_q  <= ptr_d;
         cnt_q  <= cnt_d;
         rvld_q <= {gnt1_s & ~bus.we1, gnt0_s & ~bus.we0};
         case (state_q)
            ST_CLEAR: begin
               clr_addr_q <= clr_addr_q + 1'b1;
               if (clr_addr_q == {AW{1'b1}}) begin
                  state_q    <= ST_SERVE;
                  clr_busy_q <= 1'b0;
               end else begin
                  state_q    <= ST_CLEAR;
                  clr_busy_q <= 1'b1;
               end
            end
            ST_SERVE: begin
               if (clr_req_i) begin
                  state_q    <= ST_CLEAR;
                  clr_busy_q <= 1'b1;
               end else begin
                  state_q    <= ST_SERVE;
                  clr_busy_q <= 1'b0;
               end
            end
            default: begin
               state_q    <= ST_SERVE;
               clr_addr_q <= '0;
               clr_busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.gnt0     = gnt0_s;
   assign bus.gnt1     = gnt1_s;
   assign bus.rvld0    = rvld_q[0];
   assign bus.rvld1    = rvld_q[1];
   assign bus.do0      = rvld_q[0] ? bus.ram_do : '0;
   assign bus.do1      = rvld_q[1] ? bus.ram_do : '0;
   assign bus.ram_en   = ram_en_s;
   assign bus.ram_we   = ram_we_s;
   assign bus.ram_addr = ram_addr_s;
   assign bus.ram_di   = ram_di_s;
   assign bus.ram_rst  = 1'b0;
   assign clr_busy_o   = clr_busy_q;
endmodule

// File: tb/tb_ramb4_s16_port_arbiter.sv
// Bench for ramb4_s16_port_arbiter: directed scenarios and random traffic.
// Every cycle is checked against a behavioural RAM/arbitration model.
`timescale 1ns/1ps
module tb_ramb4_s16_port_arbiter;
   localparam int          MAXB  = 4;
   localparam logic [15:0] FILLV = 16'h0000;

   logic clk = 1'b0;
   logic rst_n;
   logic clr_req;
   logic clr_busy;

   ramb4_s16_port_arbiter_if bus ();

   ramb4_s16_port_arbiter #(
      .AW(8), .DW(16), .MAX_BURST(MAXB), .FILL(FILLV), .CLR_ON_RESET(1'b1)
   ) dut (
      .clk_i(clk), .rst_n_i(rst_n), .clr_req_i(clr_req), .clr_busy_o(clr_busy), .bus(bus)
   );

   always #5 clk = ~clk;

   // Simple synchronous RAM behind the wide port; contents start as a non-FILL pattern.
   logic [15:0] mem [256] = '{default: 16'hDEAD};
   logic [15:0] ram_q;
   always @(posedge clk) begin
      if (bus.ram_en) begin
         if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_di;
         else            ram_q <= mem[bus.ram_addr];
      end
   end
   assign bus.ram_do = ram_q;

   // Reference model state.
   logic [15:0] shadow [256] = '{default: 16'hDEAD};
   bit          m_clear;
   int          m_idx, m_prio, m_streak;
   bit          m_pv [2];
   logic [15:0] m_pd [2];
   bit          m_g0, m_g1;

   logic        obs_g0, obs_g1, obs_rv0, obs_rv1, obs_busy;
   logic [15:0] obs_do0, obs_do1;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_clear  = 1'b1;
      m_idx    = 0;
      m_prio   = 0;
      m_streak = 0;
      m_pv[0]  = 1'b0;
      m_pv[1]  = 1'b0;
      m_pd[0]  = 16'h0000;
      m_pd[1]  = 16'h0000;
   endtask

   task automatic reset_checks();
      chk("rst_gnt0", bus.gnt0, 1'b0);
      chk("rst_gnt1", bus.gnt1, 1'b0);
      chk("rst_ram_en", bus.ram_en, 1'b0);
      chk("rst_ram_we", bus.ram_we, 1'b0);
      chk("rst_rvld0", bus.rvld0, 1'b0);
      chk("rst_rvld1", bus.rvld1, 1'b0);
      chk("rst_do0", bus.do0, 16'h0000);
      chk("rst_do1", bus.do1, 16'h0000);
      chk("rst_busy", clr_busy, 1'b1);
   endtask

   // One clock cycle: drive inputs, check every output against the model, then advance the model.
   task automatic step(input bit r0, input bit w0, input logic [7:0] a0, input logic [15:0] d0,
                       input bit r1, input bit w1, input logic [7:0] a1, input logic [15:0] d1,
                       input bit clr);
      int win, s;
      logic e_en, e_we;
      logic [7:0] e_addr;
      logic [15:0] e_di;
      @(negedge clk);
      bus.req0 = r0; bus.we0 = w0; bus.addr0 = a0; bus.di0 = d0;
      bus.req1 = r1; bus.we1 = w1; bus.addr1 = a1; bus.di1 = d1;
      clr_req  = clr;
      #1;
      win = -1;
      if (!m_clear) begin
         if (r0 && r1) win = m_prio;
         else if (r0)  win = 0;
         else if (r1)  win = 1;
      end
      m_g0 = (win == 0);
      m_g1 = (win == 1);
      e_en = 1'b0; e_we = 1'b0; e_addr = 8'h00; e_di = 16'h0000;
      if (m_clear) begin
         e_en = 1'b1; e_we = 1'b1; e_addr = 8'(m_idx); e_di = FILLV;
      end else if (m_g0) begin
         e_en = 1'b1; e_we = w0; e_addr = a0; e_di = d0;
      end else if (m_g1) begin
         e_en = 1'b1; e_we = w1; e_addr = a1; e_di = d1;
      end
      chk("gnt0", bus.gnt0, m_g0);
      chk("gnt1", bus.gnt1, m_g1);
      chk("ram_en", bus.ram_en, e_en);
      chk("ram_we", bus.ram_we, e_we);
      chk("ram_addr", bus.ram_addr, e_addr);
      chk("ram_di", bus.ram_di, e_di);
      chk("ram_rst", bus.ram_rst, 1'b0);
      chk("clr_busy", clr_busy, m_clear);
      chk("rvld0", bus.rvld0, m_pv[0]);
      chk("rvld1", bus.rvld1, m_pv[1]);
      chk("do0", bus.do0, m_pv[0] ? m_pd[0] : 16'h0000);
      chk("do1", bus.do1, m_pv[1] ? m_pd[1] : 16'h0000);
      obs_g0 = bus.gnt0;  obs_g1 = bus.gnt1;
      obs_rv0 = bus.rvld0; obs_rv1 = bus.rvld1;
      obs_do0 = bus.do0;  obs_do1 = bus.do1;
      obs_busy = clr_busy;
      // Read data is whatever the word held before this edge; writes land afterwards.
      m_pv[0] = m_g0 && !w0;
      m_pv[1] = m_g1 && !w1;
      if (m_pv[0]) m_pd[0] = shadow[a0];
      if (m_pv[1]) m_pd[1] = shadow[a1];
      if (m_g0 && w0) shadow[a0] = d0;
      if (m_g1 && w1) shadow[a1] = d1;
      if (win >= 0) begin
         s = (win == m_prio) ? ((m_streak < MAXB) ? m_streak + 1 : MAXB) : 1;
         m_prio   = win;
         m_streak = s;
         if (((win == 0) ? r1 : r0) && (s >= MAXB)) begin
            m_prio   = 1 - win;
            m_streak = 0;
         end
      end else if (!m_clear && (m_streak != 0)) begin
         m_prio   = 1 - m_prio;
         m_streak = 0;
      end
      if (m_clear) begin
         shadow[m_idx] = FILLV;
         if (m_idx == 255) begin
            m_clear = 1'b0;
            m_idx   = 0;
         end else begin
            m_idx++;
         end
      end else if (clr) begin
         m_clear = 1'b1;
      end
   endtask

   task automatic step_idle();
      step(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int busy_n, n1;
      bit done, got0;
      int exp_pat [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
      bit p_r [2];
      bit p_w [2];
      logic [7:0] p_a [2];
      logic [15:0] p_d [2];

      rst_n = 1'b0; clr_req = 1'b0;
      bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = 8'h00; bus.di0 = 16'h0000;
      bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = 8'h00; bus.di1 = 16'h0000;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_checks();
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Let the sweep reach address 0x80, then abort it with an asynchronous reset.
      repeat (128) step_idle();
      @(negedge clk);
      #1;
      chk("mid_addr", bus.ram_addr, 8'h80);
      #2 rst_n = 1'b0;
      #1;
      reset_checks();
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      busy_n = 0; done = 1'b0;
      for (int i = 0; i < 400 && !done; i++) begin
         step_idle();
         if (obs_busy) busy_n++;
         else          done = 1'b1;
      end
      chk("sweep_len", busy_n, 256);

      // Read of a cleared word.
      step(1'b1, 1'b0, 8'h7F, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0);
      chk("rd7f_gnt", obs_g0, 1'b1);
      step_idle();
      chk("rd7f_rvld", obs_rv0, 1'b1);
      chk("rd7f_do", obs_do0, 16'h0000);

      // Write by REQ0 followed immediately by a read from REQ1.
      step(1'b1, 1'b1, 8'h10, 16'hBEEF, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0);
      step(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 8'h10, 16'h0000, 1'b0);
      chk("wr_rd_gnt1", obs_g1, 1'b1);
      step_idle();
      chk("wr_rd_rvld1", obs_rv1, 1'b1);
      chk("wr_rd_do1", obs_do1, 16'hBEEF);
      chk("wr_rd_rvld0", obs_rv0, 1'b0);

      // Both held: bursts of MAX_BURST alternate, with no idle cycle.
      for (int i = 0; i < 12; i++) begin
         step(1'b1, 1'b0, 8'(i), 16'h0000, 1'b1, 1'b0, 8'(i + 1), 16'h0000, 1'b0);
         chk("rr_pat", obs_g1, exp_pat[i][0]);
         chk("rr_any", obs_g0 | obs_g1, 1'b1);
      end

      // REQ1 alone saturates its count, then yields quickly once REQ0 arrives.
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 8'h20, 16'h0000, 1'b0);
         chk("solo1", obs_g1, 1'b1);
      end
      n1 = 0; got0 = 1'b0;
      for (int i = 0; i < 8 && !got0; i++) begin
         step(1'b1, 1'b0, 8'h21, 16'h0000, 1'b1, 1'b0, 8'h22, 16'h0000, 1'b0);
         if (obs_g0) got0 = 1'b1;
         else        n1++;
      end
      chk("tail_gnt0", got0, 1'b1);
      chk("burst_tail", n1, 1);

      // A clear request during a granted read; a second request mid-sweep must not extend the sweep.
      step(1'b1, 1'b0, 8'h10, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1);
      chk("clr_gnt0", obs_g0, 1'b1);
      busy_n = 0; done = 1'b0;
      for (int i = 0; i < 400 && !done; i++) begin
         step(1'b1, 1'b0, 8'h33, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, (i == 100));
         if (i == 0) begin
            chk("clr_rvld0", obs_rv0, 1'b1);
            chk("clr_do0", obs_do0, 16'hBEEF);
         end
         if (obs_busy) busy_n++;
         else          done = 1'b1;
      end
      chk("sweep2_len", busy_n, 256);

      // Random traffic: requests are held until the model grants them.
      p_r[0] = 1'b0; p_r[1] = 1'b0;
      p_w[0] = 1'b0; p_w[1] = 1'b0;
      p_a[0] = 8'h00; p_a[1] = 8'h00;
      p_d[0] = 16'h0000; p_d[1] = 16'h0000;
      for (int c = 0; c < 1500; c++) begin
         for (int k = 0; k < 2; k++) begin
            if (!p_r[k] && ($urandom_range(0, 3) != 0)) begin
               p_r[k] = 1'b1;
               p_w[k] = 1'($urandom_range(0, 1));
               p_a[k] = 8'($urandom_range(0, 15));
               p_d[k] = 16'($urandom);
            end
         end
         step(p_r[0], p_w[0], p_a[0], p_d[0], p_r[1], p_w[1], p_a[1], p_d[1],
              ($urandom_range(0, 799) == 0));
         if (m_g0) p_r[0] = 1'b0;
         if (m_g1) p_r[1] = 1'b0;
      end
      repeat (2) step_idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/ramb4_s16_port_arbiter.md
Name: ramb4_s16_port_arbiter

Overview:
- Sequences and shares the 256x16 wide port of a dual-port 4Kbit block RAM between two requesters (REQ0, REQ1).
- Round-robin arbitration with bounded burst retention.
- Built-in clear sequencer fills the whole RAM with a constant after reset and on command.
- Sits between the datapath masters and the RAM's wide port. The narrow port is untouched.

Parameters:
- AW, 8: RAM word-address width (256 words).
- DW, 16: data width.
- MAX_BURST, 4: max consecutive grants to one requester while the other is waiting (1..15).
- FILL, 16'h0000: value written by the clear sequencer.
- CLR_ON_RESET, 1: 1 = run a clear sweep immediately after reset release.

Ports:
- CLK  in  1  single clock; all state changes on rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- CLR_REQ  in  1  start clear sweep (level sampled on edge).
- CLR_BUSY  out  1  clear sweep in progress.
- REQ0/REQ1  in  1  access request, held until granted.
- WE0/WE1  in  1  1 = write, 0 = read.
- ADDR0/ADDR1  in  AW  word address.
- DI0/DI1  in  DW  write data.
- GNT0/GNT1  out  1  combinational grant; transfer happens on the edge where REQn&GNTn.
- RVLD0/RVLD1  out  1  read data valid for requester n.
- DO0/DO1  out  DW  read data, meaningful only when RVLDn=1.
- RAM_EN  out  1  RAM port enable.
- RAM_WE  out  1  RAM port write enable.
- RAM_ADDR  out  AW  RAM port address.
- RAM_DI  out  DW  RAM port write data.
- RAM_RST  out  1  RAM output reset; tied 0.
- RAM_DO  in  DW  RAM port read data (valid one cycle after the enabled edge).

Behaviour:
- Reset (RST_N=0, async):
  - state = CLEAR if CLR_ON_RESET=1, else SERVE.
  - clear address counter = 0; priority pointer = 0; burst counter = 0.
  - RVLD0/1 = 0, DO0/1 = 0, CLR_BUSY = CLR_ON_RESET.
  - GNT0/1 = 0, RAM_EN = 0, RAM_WE = 0.
- CLEAR state:
  - GNT0/1 forced 0; CLR_BUSY = 1.
  - RAM_EN=1, RAM_WE=1, RAM_ADDR = counter, RAM_DI = FILL.
  - Counter increments each cycle. On the edge writing address 255: counter wraps to 0, next state SERVE, CLR_BUSY drops the following cycle.
  - Sweep takes exactly 256 cycles.
  - CLR_REQ is ignored while in CLEAR.
  - Reset mid-sweep aborts the sweep; the partial fill is left as-is, then the reset rule above applies.
- SERVE state:
  - CLR_REQ=1 sampled on an edge moves to CLEAR on that edge. A grant issued in that same cycle still completes.
  - Only one requester active: it is granted every cycle.
  - Both requesting: grant goes to the pointer's requester.
  - Pointer update after each grant to k:
    - burst counter = count of consecutive grants to k.
    - If the other requester is requesting and the counter has reached MAX_BURST, pointer flips to the other requester and the counter resets to 0.
    - If k drops REQ, pointer flips and the counter resets.
    - If the other is not requesting, the counter saturates at MAX_BURST and k keeps priority.
  - A grant to the other requester always resets the counter to 1.
- RAM mux:
  - RAM_EN = REQ & GNT of the winner.
  - RAM_WE, RAM_ADDR, RAM_DI are taken from the winner; all are 0 when there is no grant.
- Read return:
  - On a granted read (WE=0), RVLDk = 1 in the next cycle for one cycle; DOk = RAM_DO registered path (combinational pass of RAM_DO in that cycle).
  - Granted writes never assert RVLD.
  - Back-to-back reads give RVLD on consecutive cycles.
- Write/read same address in consecutive cycles: the read returns the new data. RAM write-first semantics are not relied on; there is no same-cycle overlap because the port is single.

Test Plan:
- Reset with CLR_ON_RESET=1, release RST_N -> CLR_BUSY=1 for exactly 256 cycles, RAM_ADDR 0..255 with RAM_DI=16'h0000, then GNTs respond; a read of ADDR0=8'h7F returns 16'h0000.
- REQ0 write 8'h10←16'hBEEF, next cycle REQ1 read 8'h10 -> GNT1 immediately, RVLD1 one cycle later, DO1=16'hBEEF, RVLD0 stays 0.
- REQ0 and REQ1 held continuously with MAX_BURST=4, pointer 0 -> grant pattern 0,0,0,0,1,1,1,1,0…; no cycle without a grant.
- Only REQ1 held for 10 cycles -> GNT1 all 10 cycles, counter saturates; then REQ0 rises -> REQ1 keeps at most 4 more grants (fewer if its burst count was already saturated) before GNT0.
- CLR_REQ pulse while REQ0 read granted -> that read's RVLD0 still fires; next 256 cycles GNT0/1=0 and CLR_BUSY=1; CLR_REQ re-pulsed mid-sweep has no effect (sweep length unchanged).
- RST_N asserted at sweep address 8'h80 -> outputs go to reset values asynchronously; after release the sweep restarts at address 0 and runs a full 256 cycles.
